// File: rtl/seq_mult_param_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM state encoding (ST_IDLE, ST_CALC, ST_SIGN)
//   CNT_W() : width of the iteration counter for a given operand width
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int CNT_W(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mult_cond_neg.sv
// Conditional two's-complement negation: y = neg ? -x : x.
//   x   : input value (W bits)
//   neg : 1 = negate
//   y   : result (W bits); -(-2^(W-1)) wraps to 2^(W-1), which callers
//         read as an unsigned magnitude
module mult_cond_neg #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? (~x + 1'b1) : x;

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier with signed/unsigned mode.
//   sys_clk, rst_n            : clock (rising edge), async active-low reset
//   start                     : request, sampled only in IDLE
//   signed_mode               : 1 = two's-complement operands (sampled with start)
//   multiplicand, multiplier  : operands (sampled with start)
//   busy                      : operation in progress (CALC or SIGN)
//   done                      : one-cycle pulse, product valid in the same cycle
//   product                   : 2*WIDTH-bit result, held until the next done
//   sign, zero                : flags for the held product
//
// Handshake: start is a request that is accepted on any rising edge where the
// FSM is in IDLE (including the cycle done is high); while busy is high start
// is ignored and operand changes have no effect. Exactly one done pulse follows
// each accepted start unless reset intervenes.
import mult_pkg::*;

module seq_mult_param #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_TERM = 1'b0
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 sign,
    output logic                 zero
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = CNT_W(WIDTH);

    // state is the FSM observation point for checkers.
    state_t          state;
    state_t          state_next;

    logic [PW-1:0]    ma;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mb;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             mode;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [PW-1:0]    res;
    logic [WIDTH-1:0] mb_shift;
    logic             calc_last;

    // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
    mult_cond_neg #(.W(WIDTH)) u_mag_a (
        .x   (multiplicand),
        .neg (signed_mode & multiplicand[WIDTH-1]),
        .y   (mag_a)
    );

    mult_cond_neg #(.W(WIDTH)) u_mag_b (
        .x   (multiplier),
        .neg (signed_mode & multiplier[WIDTH-1]),
        .y   (mag_b)
    );

    // Sign fix-up of the accumulated magnitude; -0 stays 0.
    mult_cond_neg #(.W(PW)) u_fix (
        .x   (acc),
        .neg (neg),
        .y   (res)
    );

    assign mb_shift  = mb >> 1;
    // Last CALC cycle: WIDTH iterations done, or (early mode) no set bits
    // left after this cycle's shift. The first CALC cycle always runs.
    assign calc_last = (cnt == CW'(WIDTH - 1)) || (EARLY_TERM && (mb_shift == '0));
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CALC;
            ST_CALC: if (calc_last) state_next = ST_SIGN;
            ST_SIGN: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            mode    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            sign    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == ST_SIGN);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ma   <= {{WIDTH{1'b0}}, mag_a};
                        mb   <= mag_b;
                        acc  <= '0;
                        cnt  <= '0;
                        neg  <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                        mode <= signed_mode;
                    end
                end
                ST_CALC: begin
                    if (mb[0]) acc <= acc + ma;
                    ma  <= ma << 1;
                    mb  <= mb_shift;
                    cnt <= cnt + 1'b1;
                end
                ST_SIGN: begin
                    product <= res;
                    // Unsigned results may have the MSB set but are never negative.
                    sign    <= mode & res[PW-1];
                    zero    <= (res == '0);
                end
                default: ;
            endcase
        end
    end

endmodule
